mac_tx_frame_build: RTL

MAC_TX_FRAME_BUILD -- requirements
Module: mac_tx_frame_build

---
 rtl/mac_pkg.sv | 19 +
 rtl/mac_tx_frame_build.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mac_pkg.sv
// Shared state type and Ethernet framing constants for the MAC transmit path.
package mac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PAD,
    ST_DROP
  } mac_state_e;

  localparam int MAC_HDR_LEN     = 14;
  localparam int MAC_MIN_PAYLOAD = 46;
  localparam int MAC_MAX_PAYLOAD = 1500;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;

endpackage

// File: rtl/mac_tx_frame_build.sv
// Builds an Ethernet frame (header, payload, zero pad) from an upper-layer byte
// stream; the registered output feeds the CRC/preamble stage.
//
// state      | meaning
// IDLE       | waiting for the first payload byte with a free output register
// HEADER     | emitting dst MAC, LOCAL_MAC and EtherType (14 bytes)
// PAYLOAD    | copying upper bytes to the output
// PAD        | emitting 8'h00 until 46 payload bytes have gone out
// DROP       | over-length tail: accept and discard until upper tlast
module mac_tx_frame_build
  import mac_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC   = 48'h00_0A_35_00_00_01,
  parameter int          MAX_PAYLOAD = MAC_MAX_PAYLOAD
) (
  input  logic        logic_clk,
  input  logic        logic_rst_n,
  input  logic [7:0]  upper_tdata_in,
  input  logic        upper_tvalid_in,
  output logic        upper_tready_out,
  input  logic        upper_tlast_in,
  input  logic [47:0] frame_dst_mac_in,
  input  logic [15:0] frame_type_in,
  output logic [7:0]  mac_tdata_out,
  output logic        mac_tvalid_out,
  input  logic        mac_tready_in,
  output logic        mac_tlast_out
);

  localparam logic [3:0]  HDR_LAST = 4'(MAC_HDR_LEN - 1);
  localparam logic [10:0] MIN_PAY  = 11'(MAC_MIN_PAYLOAD);
  localparam logic [10:0] MAX_PAY  = 11'(MAX_PAYLOAD);

  mac_state_e  state_q, state_d;
  logic [1:0]  rst_sync_q, rst_sync_d;
  logic [3:0]  hdr_idx_q, hdr_idx_d;
  logic [10:0] pay_cnt_q, pay_cnt_d;
  logic [47:0] dst_mac_q, dst_mac_d;
  logic [15:0] eth_type_q, eth_type_d;
  logic [7:0]  mac_tdata_q, mac_tdata_d;
  logic        mac_tvalid_q, mac_tvalid_d;
  logic        mac_tlast_q, mac_tlast_d;

  logic         run;
  logic         out_free;
  logic         up_accept;
  logic [10:0]  pay_cnt_inc;
  logic [111:0] hdr_vec;
  logic [111:0] hdr_shift;
  logic [7:0]   hdr_byte;

  // FSM is held in IDLE until the release of reset has passed two flops.
  assign run       = rst_sync_q[1];
  assign out_free  = !mac_tvalid_q || mac_tready_in;
  assign hdr_vec   = {dst_mac_q, LOCAL_MAC, eth_type_q};
  assign hdr_shift = hdr_vec << {hdr_idx_q, 3'b000};
  assign hdr_byte  = hdr_shift[111:104];

  assign upper_tready_out = (state_q == ST_DROP) ||
                            ((state_q == ST_PAYLOAD) && out_free);
  assign up_accept        = upper_tvalid_in && upper_tready_out;
  assign pay_cnt_inc      = pay_cnt_q + 11'd1;

  always_comb begin
    rst_sync_d   = {rst_sync_q[0], 1'b1};
    state_d      = state_q;
    hdr_idx_d    = hdr_idx_q;
    pay_cnt_d    = pay_cnt_q;
    dst_mac_d    = dst_mac_q;
    eth_type_d   = eth_type_q;
    mac_tdata_d  = mac_tdata_q;
    mac_tvalid_d = mac_tvalid_q && !mac_tready_in;
    mac_tlast_d  = mac_tlast_q;

    case (state_q)
      ST_IDLE: begin
        if (run && upper_tvalid_in && out_free) begin
          dst_mac_d  = frame_dst_mac_in;
          eth_type_d = frame_type_in;
          hdr_idx_d  = 4'd0;
          pay_cnt_d  = 11'd0;
          state_d    = ST_HEADER;
        end
      end
      ST_HEADER: begin
        if (out_free) begin
          mac_tdata_d  = hdr_byte;
          mac_tvalid_d = 1'b1;
          mac_tlast_d  = 1'b0;
          hdr_idx_d    = hdr_idx_q + 4'd1;
          if (hdr_idx_q == HDR_LAST) state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (up_accept) begin
          mac_tdata_d  = upper_tdata_in;
          mac_tvalid_d = 1'b1;
          mac_tlast_d  = 1'b0;
          pay_cnt_d    = pay_cnt_inc;
          if (upper_tlast_in) begin
            if (pay_cnt_inc >= MIN_PAY) begin
              mac_tlast_d = 1'b1;
              state_d     = ST_IDLE;
            end else begin
              state_d = ST_PAD;
            end
          end else if (pay_cnt_inc == MAX_PAY) begin
            mac_tlast_d = 1'b1;
            state_d     = ST_DROP;
          end
        end
      end
      ST_PAD: begin
        if (out_free) begin
          mac_tdata_d  = 8'h00;
          mac_tvalid_d = 1'b1;
          pay_cnt_d    = pay_cnt_inc;
          mac_tlast_d  = (pay_cnt_inc == MIN_PAY);
          if (pay_cnt_inc == MIN_PAY) state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (up_accept && upper_tlast_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      state_q      <= ST_IDLE;
      rst_sync_q   <= 2'b00;
      hdr_idx_q    <= 4'd0;
      pay_cnt_q    <= 11'd0;
      dst_mac_q    <= 48'd0;
      eth_type_q   <= 16'd0;
      mac_tdata_q  <= 8'd0;
      mac_tvalid_q <= 1'b0;
      mac_tlast_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_sync_q   <= rst_sync_d;
      hdr_idx_q    <= hdr_idx_d;
      pay_cnt_q    <= pay_cnt_d;
      dst_mac_q    <= dst_mac_d;
      eth_type_q   <= eth_type_d;
      mac_tdata_q  <= mac_tdata_d;
      mac_tvalid_q <= mac_tvalid_d;
      mac_tlast_q  <= mac_tlast_d;
    end
  end

  assign mac_tdata_out  = mac_tdata_q;
  assign mac_tvalid_out = mac_tvalid_q;
  assign mac_tlast_out  = mac_tlast_q;

endmodule
